// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg: opcode encodings, FSM state encoding and default sizes shared by the sequential ALU.
package cpu_alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_OP_W  = 5;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_SHR = 5'b00111;
  localparam logic [4:0] OP_SHL = 5'b01000;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/seq_alu_unit_if.sv
// seq_alu_unit_if: Start/Busy/Done handshake plus operand and result buses between control unit and ALU.
interface seq_alu_unit_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
);

  logic             start;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] zHigh;
  logic [WIDTH-1:0] zLow;
  logic             divZero;

  modport master (
    output start, op, a, b,
    input  busy, done, zHigh, zLow, divZero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, zHigh, zLow, divZero
  );

endinterface

// File: rtl/booth_mul_core.sv
// booth_mul_core: one radix-2 Booth step per i_step; o_prodNext is the product after the current step.
module booth_mul_core #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_prodNext
);

  localparam int CNT_W = $clog2(WIDTH);

  // One guard bit keeps acc - (-2^(WIDTH-1)) from overflowing.
  logic [WIDTH:0]     r_acc;
  logic [WIDTH:0]     r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_qPrev;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_mplierNext;

  always_comb begin
    w_sum = r_acc;
    case ({r_mplier[0], r_qPrev})
      2'b01:   w_sum = r_acc + r_mcand;
      2'b10:   w_sum = r_acc - r_mcand;
      default: w_sum = r_acc;
    endcase
    w_mplierNext = {w_sum[0], r_mplier[WIDTH-1:1]};
  end

  assign o_prodNext = {w_sum[WIDTH:1], w_mplierNext};
  assign o_last     = (r_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_qPrev  <= 1'b0;
      r_count  <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {i_multiplicand[WIDTH-1], i_multiplicand};
      r_mplier <= i_multiplier;
      r_qPrev  <= 1'b0;
      r_count  <= '0;
    end else if (i_step) begin
      r_acc    <= {w_sum[WIDTH], w_sum[WIDTH:1]};
      r_mplier <= w_mplierNext;
      r_qPrev  <= r_mplier[0];
      r_count  <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu_unit.sv
// seq_alu_unit: multi-cycle ALU with Start/Busy/Done handshake, Booth MUL and optional signed DIV.
// Define ALU_DIV_EN to compile in the restoring divider and FIX state; otherwise DIV acts as undefined.
module seq_alu_unit
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OP_W  = ALU_OP_W
) (
  input  logic          i_clk,
  input  logic          i_clear,
  seq_alu_unit_if.slave bus
);

  localparam int SH_W  = $clog2(WIDTH);

  alu_state_t         r_state;
  alu_state_t         w_stateNext;
  logic               r_isMul;
  logic               r_done;
  logic               r_divZero;
  logic [WIDTH-1:0]   r_zHigh;
  logic [WIDTH-1:0]   r_zLow;
  logic               w_doneNext;
  logic               w_divZeroNext;
  logic [WIDTH-1:0]   w_zHighNext;
  logic [WIDTH-1:0]   w_zLowNext;
  logic [WIDTH-1:0]   w_single;
  logic               w_accept;
  logic               w_isMul;
  logic               w_isDiv;
  logic               w_divByZero;
  logic               w_mulStep;
  logic               w_mulLast;
  logic [2*WIDTH-1:0] w_mulProdNext;

  assign w_accept    = bus.start && (r_state == S_IDLE);
  assign w_isMul     = (bus.op == OP_W'(OP_MUL));
  assign w_divByZero = (bus.b == '0);
`ifdef ALU_DIV_EN
  assign w_isDiv     = (bus.op == OP_W'(OP_DIV));
`else
  assign w_isDiv     = 1'b0;
`endif

  always_comb begin
    w_single = '0;
    case (bus.op)
      OP_W'(OP_ADD): w_single = bus.a + bus.b;
      OP_W'(OP_SUB): w_single = bus.a - bus.b;
      OP_W'(OP_AND): w_single = bus.a & bus.b;
      OP_W'(OP_OR):  w_single = bus.a | bus.b;
      OP_W'(OP_SHR): w_single = bus.a >> bus.b[SH_W-1:0];
      OP_W'(OP_SHL): w_single = bus.a << bus.b[SH_W-1:0];
      OP_W'(OP_NEG): w_single = -bus.b;
      OP_W'(OP_NOT): w_single = ~bus.b;
      default:       w_single = '0;
    endcase
  end

  booth_mul_core #(.WIDTH(WIDTH)) u_mul (
    .i_clk          (i_clk),
    .i_clear        (i_clear),
    .i_load         (w_accept && w_isMul),
    .i_step         (w_mulStep),
    .i_multiplicand (bus.a),
    .i_multiplier   (bus.b),
    .o_last         (w_mulLast),
    .o_prodNext     (w_mulProdNext)
  );

`ifdef ALU_DIV_EN
  // Divider works on magnitudes; signs are reapplied in FIX.
  logic [WIDTH-1:0] r_divQ;
  logic [WIDTH-1:0] r_divRem;
  logic [WIDTH-1:0] r_divisor;
  logic             r_negQ;
  logic             r_negR;
  logic [SH_W-1:0]  r_divCount;
  logic             w_divStep;
  logic [WIDTH:0]   w_remShift;
  logic [WIDTH:0]   w_remDiff;

  assign w_remShift = {r_divRem, r_divQ[WIDTH-1]};
  assign w_remDiff  = w_remShift - {1'b0, r_divisor};

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_divQ     <= '0;
      r_divRem   <= '0;
      r_divisor  <= '0;
      r_negQ     <= 1'b0;
      r_negR     <= 1'b0;
      r_divCount <= '0;
    end else if (w_accept && w_isDiv) begin
      r_divQ     <= bus.a[WIDTH-1] ? -bus.a : bus.a;
      r_divisor  <= bus.b[WIDTH-1] ? -bus.b : bus.b;
      r_divRem   <= '0;
      r_negQ     <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      r_negR     <= bus.a[WIDTH-1];
      r_divCount <= '0;
    end else if (w_divStep) begin
      r_divRem   <= w_remDiff[WIDTH] ? w_remShift[WIDTH-1:0] : w_remDiff[WIDTH-1:0];
      r_divQ     <= {r_divQ[WIDTH-2:0], ~w_remDiff[WIDTH]};
      r_divCount <= r_divCount + 1'b1;
    end
  end
`endif

  always_comb begin
    w_stateNext   = r_state;
    w_doneNext    = 1'b0;
    w_zHighNext   = r_zHigh;
    w_zLowNext    = r_zLow;
    w_divZeroNext = r_divZero;
    w_mulStep     = 1'b0;
`ifdef ALU_DIV_EN
    w_divStep     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_divZeroNext = 1'b0;
          if (w_isMul || (w_isDiv && !w_divByZero)) begin
            w_stateNext = S_RUN;
          end else if (w_isDiv) begin
            w_doneNext    = 1'b1;
            w_zHighNext   = bus.a;
            w_zLowNext    = '1;
            w_divZeroNext = 1'b1;
          end else begin
            w_doneNext  = 1'b1;
            w_zHighNext = '0;
            w_zLowNext  = w_single;
          end
        end
      end
      S_RUN: begin
        if (r_isMul) begin
          w_mulStep = 1'b1;
          if (w_mulLast) begin
            w_stateNext = S_IDLE;
            w_doneNext  = 1'b1;
            w_zHighNext = w_mulProdNext[2*WIDTH-1:WIDTH];
            w_zLowNext  = w_mulProdNext[WIDTH-1:0];
          end
        end else begin
`ifdef ALU_DIV_EN
          w_divStep = 1'b1;
          if (r_divCount == SH_W'(WIDTH - 1)) begin
            w_stateNext = S_FIX;
          end
`else
          w_stateNext = S_IDLE;
`endif
        end
      end
      S_FIX: begin
`ifdef ALU_DIV_EN
        w_doneNext  = 1'b1;
        w_zLowNext  = r_negQ ? -r_divQ : r_divQ;
        w_zHighNext = r_negR ? -r_divRem : r_divRem;
`endif
        w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_state   <= S_IDLE;
      r_isMul   <= 1'b0;
      r_done    <= 1'b0;
      r_divZero <= 1'b0;
      r_zHigh   <= '0;
      r_zLow    <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_done    <= w_doneNext;
      r_divZero <= w_divZeroNext;
      r_zHigh   <= w_zHighNext;
      r_zLow    <= w_zLowNext;
      if (w_accept) begin
        r_isMul <= w_isMul;
      end
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.zHigh   = r_zHigh;
  assign bus.zLow    = r_zLow;
  assign bus.divZero = r_divZero;

endmodule
